// File: rtl/qpd_capture_seq.sv
// Quarter-period-delay trigger initiator: arms the delay block, waits for the delayed trigger
// (with timeout), captures an ADC burst into a 4-entry FIFO and streams it out valid/ready.
// Optional macro QPD_TRIG_LATENCY_EN adds the trig_latency measurement output.
module qpd_capture_seq #(
    parameter int sample_frequency = 100000,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int DATA_W           = 16
) (
    input  logic              sclock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        cfg_delay,
    input  logic [7:0]        cfg_nsamples,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              trigger,
`ifdef QPD_TRIG_LATENCY_EN
    output logic [31:0]       trig_latency,
`endif
    output logic              rt,
    output logic [7:0]        count_quater_period,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARM       = 3'd1;
    localparam logic [2:0] S_WAIT_TRIG = 3'd2;
    localparam logic [2:0] S_CAPTURE   = 3'd3;
    localparam logic [2:0] S_FLUSH     = 3'd4;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20) || sample_frequency <= 0) begin : g_bad_params
        $error("qpd_capture_seq: illegal parameter value");
    end

    logic [2:0]        state_reg, state_next;
    logic [TW-1:0]     timer_reg;
    logic [8:0]        sample_cnt_reg;
    logic [8:0]        nsamp_reg;
    logic [7:0]        delay_reg;
    logic              done_reg, done_next;
    logic              timeout_reg;
    logic              overflow_reg;

    logic [DATA_W-1:0] fifo_data_mem [4];
    logic              fifo_last_mem [4];
    logic [1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [2:0]        fifo_count_reg;

    logic fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic cap_valid, cap_last, timer_expired;

    assign fifo_empty    = (fifo_count_reg == 3'd0);
    assign fifo_full     = (fifo_count_reg == 3'd4);
    assign fifo_pop      = !fifo_empty && out_ready;
    assign cap_valid     = (state_reg == S_CAPTURE) && adc_valid;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign fifo_push     = cap_valid && (!fifo_full || fifo_pop);
    assign cap_last      = ((sample_cnt_reg + 9'd1) == nsamp_reg);
    assign timer_expired = (timer_reg == TIMER_LAST);

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_ARM;
            end
            S_ARM: begin
                state_next = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                if (trigger) begin
                    state_next = S_CAPTURE;
                end else if (timer_expired) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (cap_valid && cap_last) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                // No pushes happen here, so the pop of the only entry empties the FIFO.
                if (fifo_empty || (fifo_count_reg == 3'd1 && fifo_pop)) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            timer_reg      <= '0;
            sample_cnt_reg <= '0;
            nsamp_reg      <= '0;
            delay_reg      <= '0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        delay_reg      <= cfg_delay;
                        nsamp_reg      <= (cfg_nsamples == 8'd0) ? 9'd256 : {1'b0, cfg_nsamples};
                        sample_cnt_reg <= '0;
                        timeout_reg    <= 1'b0;
                        overflow_reg   <= 1'b0;
                    end
                end
                S_WAIT_TRIG: begin
                    if (trigger || timer_expired) begin
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                    if (!trigger && timer_expired) timeout_reg <= 1'b1;
                end
                S_CAPTURE: begin
                    // Dropped samples still advance the count so the burst length is fixed in time.
                    if (cap_valid) begin
                        sample_cnt_reg <= sample_cnt_reg + 9'd1;
                        if (!fifo_push) overflow_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge sclock) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 3'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 3'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_ff @(posedge sclock) begin
        if (fifo_push) begin
            fifo_data_mem[wr_ptr_reg] <= adc_data;
            fifo_last_mem[wr_ptr_reg] <= cap_last;
        end
    end

`ifdef QPD_TRIG_LATENCY_EN
    logic [31:0] latency_reg;

    // The wait timer already counts from the first WAIT_TRIG cycle, so it is the latency.
    always_ff @(posedge sclock) begin
        if (reset) begin
            latency_reg <= '0;
        end else if (state_reg == S_WAIT_TRIG) begin
            if (trigger) begin
                latency_reg <= 32'(timer_reg);
            end else if (timer_expired) begin
                latency_reg <= 32'hFFFF_FFFF;
            end
        end
    end

    assign trig_latency = latency_reg;
`endif

    assign rt                  = (state_reg == S_WAIT_TRIG);
    assign busy                = (state_reg != S_IDLE);
    assign done                = done_reg;
    assign timeout             = timeout_reg;
    assign overflow            = overflow_reg;
    assign count_quater_period = delay_reg;
    assign out_valid           = !fifo_empty;
    assign out_data            = fifo_empty ? '0 : fifo_data_mem[rd_ptr_reg];
    assign out_last            = !fifo_empty && fifo_last_mem[rd_ptr_reg];

endmodule

// File: tb/tb_qpd_capture_seq.sv
// Bench for qpd_capture_seq: directed table of measurements, hand sequences for reset abort,
// and randomized measurements checked against a queue-based model of the capture flow.
module tb_qpd_capture_seq;
    localparam int DW  = 16;
    localparam int TMO = 16;

    logic          sclock = 1'b0;
    logic          reset, start, adc_valid, trigger, out_ready;
    logic [7:0]    cfg_delay, cfg_nsamples;
    logic [DW-1:0] adc_data;
    logic          rt, out_valid, out_last, busy, done, timeout, overflow;
    logic [7:0]    count_quater_period;
    logic [DW-1:0] out_data;
`ifdef QPD_TRIG_LATENCY_EN
    logic [31:0]   trig_latency;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } item_t;
    item_t q[$];

    typedef struct {
        logic [7:0] d;
        logic [7:0] ns;
        int         k;
        int         vpct;
        int         rpct;
        bit         hold;
        bit         spur;
        int         exp_rt;
        int         exp_nout;
        int         exp_nlast;
        bit         exp_to;
        bit         exp_ov;
    } vec_t;

    qpd_capture_seq #(
        .sample_frequency(100000),
        .TIMEOUT_CYCLES  (TMO),
        .DATA_W          (DW)
    ) dut (
        .sclock             (sclock),
        .reset              (reset),
        .start              (start),
        .cfg_delay          (cfg_delay),
        .cfg_nsamples       (cfg_nsamples),
        .adc_valid          (adc_valid),
        .adc_data           (adc_data),
        .trigger            (trigger),
`ifdef QPD_TRIG_LATENCY_EN
        .trig_latency       (trig_latency),
`endif
        .rt                 (rt),
        .count_quater_period(count_quater_period),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_last           (out_last),
        .out_ready          (out_ready),
        .busy               (busy),
        .done               (done),
        .timeout            (timeout),
        .overflow           (overflow)
    );

    always #5 sclock = ~sclock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sclock);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full measurement: start, wait (trigger after k rt-cycles, or never if k >= TMO),
    // capture/drain against a FIFO queue model. abort_at >= 0 resets mid-capture.
    task automatic run_meas(input logic [7:0] d, input logic [7:0] ns, input int k,
                            input int vpct, input int rpct, input bit hold, input bit spur,
                            input int abort_at,
                            output int rt_cyc, output int nout, output int nlast);
        int    n, cnt;
        bit    trig_seen, ov, fin;
        item_t it;
        n = (ns == 8'd0) ? 256 : int'(ns);
        rt_cyc = 0; nout = 0; nlast = 0; cnt = 0; ov = 0; trig_seen = 0; fin = 0;
        q.delete();

        start = 1'b1; cfg_delay = d; cfg_nsamples = ns;
        tick();
        start = 1'b0; cfg_delay = 8'($urandom); cfg_nsamples = 8'($urandom);
        chk1("arm_busy", busy, 1'b1);
        chk1("arm_rt", rt, 1'b0);
        chk32("arm_delay", 32'(count_quater_period), 32'(d));
        chk1("start_clears_timeout", timeout, 1'b0);
        chk1("start_clears_overflow", overflow, 1'b0);

        for (int i = 0; i < TMO; i++) begin
            tick();
            chk1("wait_rt", rt, 1'b1);
            chk1("wait_busy", busy, 1'b1);
            chk1("wait_done", done, 1'b0);
            chk32("wait_delay", 32'(count_quater_period), 32'(d));
            if (rt === 1'b1) rt_cyc++;
            trigger   = (i == k);
            adc_valid = (i == k) ? 1'b1 : 1'($urandom);
            adc_data  = 16'hBAD0;
            start     = spur && (i == 0);
            if (start) begin
                cfg_delay    = ~d;
                cfg_nsamples = ns + 8'd3;
            end
            if (i == k) begin
                trig_seen = 1;
                break;
            end
        end
        tick();
        trigger = 1'b0; start = 1'b0; adc_valid = 1'b0;
        chk1("post_wait_rt", rt, 1'b0);

        if (!trig_seen) begin
            chk1("to_busy", busy, 1'b0);
            chk1("to_done", done, 1'b1);
            chk1("to_flag", timeout, 1'b1);
`ifdef QPD_TRIG_LATENCY_EN
            chk32("to_latency", trig_latency, 32'hFFFF_FFFF);
`endif
            tick();
            chk1("to_done_pulse", done, 1'b0);
            chk1("to_sticky", timeout, 1'b1);
            $display("meas d=%0d n=%0d k=%0d rt=%0d timeout", d, n, k, rt_cyc);
            return;
        end
`ifdef QPD_TRIG_LATENCY_EN
        chk32("latency", trig_latency, 32'(k));
`endif

        for (int iter = 0; iter < 3000; iter++) begin
            fin = (cnt == n) && (q.size() == 0);
            chk1("cap_busy", busy, !fin);
            chk1("cap_done", done, fin);
            chk1("cap_rt", rt, 1'b0);
            chk1("cap_timeout", timeout, 1'b0);
            chk1("cap_overflow", overflow, ov);
            chk1("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk32("out_data", 32'(out_data), 32'(q[0].data));
                chk1("out_last", out_last, q[0].last);
            end
            if (fin) begin
                out_ready = 1'b0; adc_valid = 1'b0; trigger = 1'b0;
                tick();
                chk1("done_single_pulse", done, 1'b0);
                break;
            end
            chk32("cap_delay", 32'(count_quater_period), 32'(d));
            if (abort_at >= 0 && iter == abort_at) begin
                reset = 1'b1; adc_valid = 1'b0; out_ready = 1'b0; trigger = 1'b0;
                tick();
                reset = 1'b0;
                chk1("rst_rt", rt, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_out_valid", out_valid, 1'b0);
                chk1("rst_done", done, 1'b0);
                chk1("rst_overflow", overflow, 1'b0);
                chk32("rst_delay", 32'(count_quater_period), 32'd0);
                tick();
                chk1("rst_no_done", done, 1'b0);
                chk1("rst_idle", busy, 1'b0);
                $display("meas d=%0d n=%0d k=%0d aborted by reset after %0d samples", d, n, k, cnt);
                return;
            end
            out_ready = (hold && cnt < n) ? 1'b0 : (int'($urandom_range(0, 99)) < rpct);
            adc_valid = (cnt < n) ? (int'($urandom_range(0, 99)) < vpct) : 1'($urandom);
            adc_data  = DW'($urandom);
            trigger   = 1'($urandom);
            start     = spur && (iter == 1);
            cfg_delay = 8'($urandom);
            if (q.size() != 0 && out_ready) begin
                nout++;
                if (q[0].last) nlast++;
                void'(q.pop_front());
            end
            if (cnt < n && adc_valid) begin
                if (q.size() < 4) begin
                    it.data = adc_data;
                    it.last = (cnt + 1 == n);
                    q.push_back(it);
                end else begin
                    ov = 1;
                end
                cnt++;
            end
            tick();
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL capture_bound: got no done after 3000 cycles, required done");
        end
        $display("meas d=%0d n=%0d k=%0d rt=%0d out=%0d last=%0d ov=%0b", d, n, k, rt_cyc, nout, nlast, ov);
    endtask

    initial begin
        vec_t tbl[7];
        int   rc, no, nl;

        reset = 1'b1; start = 1'b0; cfg_delay = '0; cfg_nsamples = '0;
        adc_valid = 1'b0; adc_data = '0; trigger = 1'b0; out_ready = 1'b0;

        //          d      ns     k    v    r    hold spur rt   nout last to ov
        tbl[0] = '{8'd9,  8'd4,  100, 100, 100, 0,   0,   16,  0,   0,   1, 0};
        tbl[1] = '{8'd5,  8'd3,  7,   100, 100, 0,   0,   8,   3,   1,   0, 0};
        tbl[2] = '{8'd1,  8'd6,  2,   100, 100, 1,   0,   3,   4,   0,   0, 1};
        tbl[3] = '{8'd2,  8'd0,  0,   100, 100, 0,   0,   1,   256, 1,   0, 0};
        tbl[4] = '{8'd3,  8'd2,  15,  100, 100, 0,   0,   16,  2,   1,   0, 0};
        tbl[5] = '{8'd7,  8'd3,  4,   100, 100, 0,   1,   5,   3,   1,   0, 0};
        tbl[6] = '{8'hAA, 8'd5,  1,   40,  100, 0,   0,   2,   5,   1,   0, 0};

        repeat (3) tick();
        chk1("reset_rt", rt, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_timeout", timeout, 1'b0);
        chk1("reset_overflow", overflow, 1'b0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_out_last", out_last, 1'b0);
        chk32("reset_out_data", 32'(out_data), 32'd0);
        chk32("reset_delay", 32'(count_quater_period), 32'd0);
`ifdef QPD_TRIG_LATENCY_EN
        chk32("reset_latency", trig_latency, 32'd0);
`endif
        reset = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        chk1("idle_trigger_ignored_busy", busy, 1'b0);
        chk1("idle_trigger_ignored_rt", rt, 1'b0);

        for (int t = 0; t < 7; t++) begin
            run_meas(tbl[t].d, tbl[t].ns, tbl[t].k, tbl[t].vpct, tbl[t].rpct,
                     tbl[t].hold, tbl[t].spur, -1, rc, no, nl);
            chk32($sformatf("tbl%0d_rt_cycles", t), 32'(rc), 32'(tbl[t].exp_rt));
            chk32($sformatf("tbl%0d_nout", t), 32'(no), 32'(tbl[t].exp_nout));
            chk32($sformatf("tbl%0d_nlast", t), 32'(nl), 32'(tbl[t].exp_nlast));
            chk1($sformatf("tbl%0d_timeout", t), timeout, tbl[t].exp_to);
            chk1($sformatf("tbl%0d_overflow", t), overflow, tbl[t].exp_ov);
            tick();
        end

        run_meas(8'd6, 8'd8, 2, 100, 100, 1, 0, 3, rc, no, nl);
        run_meas(8'd4, 8'd3, 1, 100, 100, 0, 0, -1, rc, no, nl);
        chk32("after_reset_nout", 32'(no), 32'd3);
        chk32("after_reset_nlast", 32'(nl), 32'd1);
        chk32("after_reset_rt", 32'(rc), 32'd2);

        for (int r = 0; r < 40; r++) begin
            run_meas(8'($urandom), 8'($urandom_range(1, 9)), int'($urandom_range(0, 18)),
                     int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
                     ($urandom_range(0, 3) == 0), 1'($urandom), -1, rc, no, nl);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qpd_capture_seq.md
Name: qpd_capture_seq

Overview:
Initiator for the quarter-period-delay trigger handshake. On a start command from the C server it:
- presents the delay value and raises the trigger request;
- waits for the delayed trigger, with a timeout;
- captures a burst of ADC samples into a 4-entry FIFO;
- streams the samples out on a valid/ready interface.

It sits between the server register bank, the delay block (rt / count_quater_period / trigger) and the ADC sample path.

Parameters:
sample_frequency, 100000, ADC sample rate in Hz; informational, used only for documentation and bench stimulus spacing.
TIMEOUT_CYCLES, 1024, sclock cycles to wait in WAIT_TRIG before aborting; legal range 2..2^20.
DATA_W, 16, ADC sample width.

Ports:
sclock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle command pulse; honoured only when busy=0
cfg_delay  in  8  quarter-period delay count to request
cfg_nsamples  in  8  burst length; 0 means 256
adc_valid  in  1  ADC sample strobe
adc_data  in  DATA_W  ADC sample
trigger  in  1  delayed trigger from delay block
rt  out  1  trigger request level to delay block
count_quater_period  out  8  delay value to delay block
out_valid  out  1  FIFO head valid
out_data  out  DATA_W  FIFO head data
out_last  out  1  head is final sample of burst
out_ready  in  1  downstream accept
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse at end of measurement (normal or timeout)
timeout  out  1  sticky; set on trigger timeout, cleared by next accepted start
overflow  out  1  sticky; set when a sample is dropped on full FIFO, cleared by next accepted start

Behaviour:
- Reset: state=IDLE; all outputs are 0; count_quater_period=0; FIFO emptied; timer and sample counter are 0. Reset mid-operation aborts immediately with no done pulse.
- IDLE:
  - rt=0.
  - On start=1, latch cfg_delay into count_quater_period and cfg_nsamples into nsamp_r (0 becomes 256, 9-bit register).
  - Clear timeout and overflow, then go to ARM.
  - start while busy is ignored; config inputs are not sampled.
- ARM: exactly 1 cycle. count_quater_period is stable at least one cycle before rt rises. Next state is WAIT_TRIG, with rt=1 from the first WAIT_TRIG cycle.
- WAIT_TRIG:
  - rt=1; timer increments each cycle from 0.
  - trigger=1 sampled: next cycle rt=0, go to CAPTURE, timer cleared.
  - Timer reaches TIMEOUT_CYCLES-1 with no trigger: next cycle rt=0, timeout=1, done=1 for one cycle, go to IDLE.
  - trigger and timer expiry in the same cycle: trigger wins.
  - trigger in IDLE, ARM, CAPTURE or FLUSH is ignored.
- CAPTURE:
  - Samples start the cycle after trigger; an adc_valid coincident with trigger is not captured.
  - Each adc_valid cycle increments the sample counter.
  - Each sample is pushed to the FIFO with last = (counter+1 == nsamp_r).
  - FIFO full with no pop the same cycle: the sample is dropped, overflow=1, and the counter still increments, so burst length is fixed in time.
  - When the counter reaches nsamp_r, go to FLUSH.
- FLUSH:
  - Wait for the FIFO to empty.
  - The cycle after the last pop, done=1 for one cycle, then IDLE.
- FIFO:
  - 4 entries; push and pop in the same cycle are allowed when full (net zero).
  - out_valid = not empty; pop on out_valid & out_ready.
  - If the final sample was dropped, out_last is never asserted for that burst; overflow flags it.
  - The FIFO is not cleared on a new start; it is always empty in IDLE by construction.
- Widths: timer is clog2(TIMEOUT_CYCLES) bits; sample counter is 9 bits; no wrap is possible within a burst.

Optional Feature:
Macro: QPD_TRIG_LATENCY_EN.
- Defined:
  - Adds output trig_latency [31:0], reset 0.
  - Counts sclock cycles from the first WAIT_TRIG cycle to the cycle trigger is sampled (first-cycle trigger gives 0).
  - Latched on trigger and held until the next trigger.
  - On timeout it is loaded with 32'hFFFFFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Normal burst: start with cfg_delay=5, cfg_nsamples=3; trigger 7 cycles after rt rises; 3 adc_valid; out_ready=1 -> rt high for 8 cycles, 3 samples out in order, last on the 3rd, one done pulse, timeout=0, overflow=0.
2. Timeout: TIMEOUT_CYCLES=16, start, trigger never asserted -> rt high exactly 16 cycles, then timeout=1, done pulse, busy=0; the next start clears timeout.
3. Overflow: cfg_nsamples=6, out_ready=0 and 6 back-to-back adc_valid -> 4 samples retained, overflow=1, no out_last; releasing out_ready drains 4, then done.
4. nsamples=0: 256 samples captured with out_ready=1 -> out_last only on the 256th, done once.
5. Edge cases:
   - start while busy is ignored, and count_quater_period is unchanged.
   - adc_valid coincident with trigger is not captured.
   - trigger coincident with timer expiry gives a capture, not a timeout.
6. Reset mid-CAPTURE -> next cycle rt=0, busy=0, out_valid=0, no done pulse; a fresh start runs normally. With QPD_TRIG_LATENCY_EN, case 1 gives trig_latency=7 and case 2 gives 32'hFFFFFFFF.
